period_detector: RTL and testbench

PERIOD_DETECTOR -- requirements
Module: period_detector

---
 rtl/period_detector.sv | 170 +++++++++++++++++
 tb/tb_period_detector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_detector.sv
`default_nettype none
// ============================================================================
//  Module      : period_detector
//  Description : Measures the period of an oscillator phase-count ramp.
//                A ramp restart (count falls below its previous value) marks
//                a cycle boundary. The period is declared locked once two
//                consecutive measured periods agree, and the lock is dropped
//                when a mismatching period arrives. If no boundary is seen
//                for TIMEOUT_MAX cycles, loss-of-signal is flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_detector #(
    parameter logic [15:0] TIMEOUT_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] count,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEARCH  = 3'd1,
        S_MEASURE = 3'd2,
        S_CONFIRM = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_count_d;
    logic [15:0] r_cnt;
    logic [15:0] r_cand;

    logic        w_wrap;
    logic [15:0] w_meas;
    logic        w_timeout_hit;

    // A ramp restart is the only event that marks a cycle boundary.
    assign w_wrap        = (count < r_count_d);
    // The running counter holds the cycles elapsed since the previous boundary.
    assign w_meas        = r_cnt;
    // Loss-of-signal only when the counter saturates without a boundary now.
    assign w_timeout_hit = (r_cnt == TIMEOUT_MAX) && !w_wrap;

    // Delay the count stream by one cycle for boundary detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count_d <= 16'd0;
        end else begin
            r_count_d <= count;
        end
    end

    // Free-running cycle counter: restart at 1 on each boundary, saturate.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= 16'd0;
        end else if (w_wrap) begin
            r_cnt <= 16'd1;
        end else if (r_cnt != TIMEOUT_MAX) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Acquisition state machine with registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_cand       <= 16'd0;
            period       <= 16'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            period_valid <= 1'b0;
            timeout      <= 1'b0;

            if (!enable) begin
                // Disabling discards all acquisition history.
                r_state <= S_IDLE;
                r_cand  <= 16'd0;
                period  <= 16'd0;
                locked  <= 1'b0;
            end else if (clear) begin
                // Restart acquisition; a coincident boundary is ignored.
                r_state <= S_SEARCH;
                r_cand  <= 16'd0;
                period  <= 16'd0;
                locked  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_SEARCH;
                        locked  <= 1'b0;
                    end

                    S_SEARCH: begin
                        // The first boundary only starts a measurement; the
                        // partial interval before it is meaningless.
                        if (w_wrap) begin
                            r_state <= S_MEASURE;
                        end
                    end

                    S_MEASURE: begin
                        if (w_timeout_hit) begin
                            r_state <= S_SEARCH;
                            period  <= 16'd0;
                            timeout <= 1'b1;
                        end else if (w_wrap) begin
                            r_state <= S_CONFIRM;
                            r_cand  <= w_meas;
                        end
                    end

                    S_CONFIRM: begin
                        if (w_timeout_hit) begin
                            r_state <= S_SEARCH;
                            period  <= 16'd0;
                            timeout <= 1'b1;
                        end else if (w_wrap) begin
                            if (w_meas == r_cand) begin
                                r_state      <= S_LOCKED;
                                period       <= w_meas;
                                period_valid <= 1'b1;
                                locked       <= 1'b1;
                            end else begin
                                // Keep chasing: the newest period becomes
                                // the candidate to confirm.
                                r_cand <= w_meas;
                            end
                        end
                    end

                    S_LOCKED: begin
                        if (w_timeout_hit) begin
                            r_state <= S_SEARCH;
                            period  <= 16'd0;
                            locked  <= 1'b0;
                            timeout <= 1'b1;
                        end else if (w_wrap) begin
                            if (w_meas == period) begin
                                period_valid <= 1'b1;
                            end else begin
                                // Period output holds its last locked value
                                // while the new candidate is confirmed.
                                r_state <= S_CONFIRM;
                                r_cand  <= w_meas;
                                locked  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_period_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_period_detector
//  Description : Scoreboard bench for period_detector. A reference model that
//                works on boundary timestamps predicts outputs and strobes;
//                a monitor compares them against the design every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_period_detector;

    localparam logic [15:0] TMAX = 16'hFFFF;

    logic        clk   = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] count = 16'd0;
    logic        enable = 1'b0;
    logic        clear  = 1'b0;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    period_detector #(.TIMEOUT_MAX(TMAX)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .count        (count),
        .enable       (enable),
        .clear        (clear),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int unsigned cyc;
        bit          is_to;
        logic [15:0] per;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state: timestamps of ramp restarts, not a state machine.
    int unsigned cyc = 0;
    logic [15:0] m_prev = 16'd0;
    bit          m_run = 1'b0;        // enable was already high last cycle
    int          m_wraps = 0;         // boundaries seen since acquisition start
    int unsigned m_last_wrap = 0;
    int unsigned m_last_meas = 0;
    logic [15:0] m_period = 16'd0;
    bit          m_locked = 1'b0;
    int          timeouts_seen = 0;

    bit          mw;
    int unsigned mel;
    ev_t         mev;

    // Reference model: predict register contents after each active edge.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_prev      = 16'd0;
            m_run       = 1'b0;
            m_wraps     = 0;
            m_last_wrap = cyc;
            m_period    = 16'd0;
            m_locked    = 1'b0;
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            mw  = (count < m_prev);
            mel = cyc - m_last_wrap;
            if (!enable) begin
                m_run = 1'b0; m_wraps = 0; m_period = 16'd0; m_locked = 1'b0;
            end else if (!m_run || clear) begin
                m_run = 1'b1; m_wraps = 0; m_period = 16'd0; m_locked = 1'b0;
            end else if (m_wraps >= 1 && !mw && mel == int'(TMAX)) begin
                m_wraps = 0; m_period = 16'd0; m_locked = 1'b0;
                mev.cyc = cyc; mev.is_to = 1'b1; mev.per = 16'd0;
                exp_q.push_back(mev);
            end else if (mw) begin
                // Locked exactly when the last two complete periods agree.
                if (m_wraps >= 2 && mel == m_last_meas) begin
                    m_locked = 1'b1;
                    m_period = mel[15:0];
                    mev.cyc = cyc; mev.is_to = 1'b0; mev.per = mel[15:0];
                    exp_q.push_back(mev);
                end else begin
                    m_locked = 1'b0;
                end
                if (m_wraps >= 1) m_last_meas = mel;
                if (m_wraps < 2) m_wraps = m_wraps + 1;
            end
            if (mw) m_last_wrap = cyc;
            m_prev = count;
        end
    end

    ev_t pe;

    // Monitor: compare levels each cycle and match strobes to the scoreboard.
    always @(negedge clk) begin
        n_checks++;
        if (locked !== m_locked) begin
            n_fail++;
            $display("FAIL locked @cyc %0d: got %b expected %b", cyc, locked, m_locked);
        end
        n_checks++;
        if (period !== m_period) begin
            n_fail++;
            $display("FAIL period @cyc %0d: got %0d expected %0d", cyc, period, m_period);
        end
        n_checks++;
        if (period_valid && timeout) begin
            n_fail++;
            $display("FAIL strobe_overlap @cyc %0d: got both strobes expected at most one", cyc);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            pe = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missed_strobe: got none expected %s at cyc %0d",
                     pe.is_to ? "timeout" : "period_valid", pe.cyc);
        end
        if (period_valid || timeout) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe @cyc %0d: got valid=%b timeout=%b expected none",
                         cyc, period_valid, timeout);
            end else begin
                pe = exp_q.pop_front();
                if (pe.cyc != cyc || pe.is_to != timeout ||
                    (!pe.is_to && pe.per != period)) begin
                    n_fail++;
                    $display("FAIL strobe @cyc %0d: got timeout=%b period=%0d expected cyc %0d timeout=%b period=%0d",
                             cyc, timeout, period, pe.cyc, pe.is_to, pe.per);
                end
            end
        end
        if (timeout) timeouts_seen++;
    end

    // Oscillator ramp generator state.
    logic [15:0] phase  = 16'd1;
    int          div    = 100;
    bit          frozen = 1'b0;
    bit          hit_wrap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Advance one clock; clr_wrap raises clear in the same cycle as a ramp restart.
    task automatic step(input bit en, input bit clr, input bit clr_wrap);
        @(posedge clk);
        #1;
        if (!frozen) phase = (int'(phase) >= div) ? 16'd1 : phase + 16'd1;
        count    = frozen ? 16'd1 : phase;
        hit_wrap = (count == 16'd1);
        enable   = en;
        clear    = clr | (clr_wrap & hit_wrap);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_period", {16'd0, period}, 32'd0);
        chk("reset_valid", {31'd0, period_valid}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        n_rst = 1'b1;

        // Lock on divider 100.
        div = 100;
        run(350);
        chk("lock100_locked", {31'd0, locked}, 32'd1);
        chk("lock100_period", {16'd0, period}, 32'd100);

        // One-cycle enable drop while locked, then reacquire.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("disable_locked", {31'd0, locked}, 32'd0);
        chk("disable_period", {16'd0, period}, 32'd0);
        run(350);
        chk("relock100_period", {16'd0, period}, 32'd100);

        // Divider change to 50: drop, hold period, relock.
        div = 50;
        run(200);
        chk("lock50_locked", {31'd0, locked}, 32'd1);
        chk("lock50_period", {16'd0, period}, 32'd50);

        // Clear coincident with a matching restart while locked at 10.
        div = 10;
        run(60);
        chk("lock10_period", {16'd0, period}, 32'd10);
        hit_wrap = 1'b0;
        for (int i = 0; i < 20 && !hit_wrap; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("clear_locked", {31'd0, locked}, 32'd0);
        chk("clear_period", {16'd0, period}, 32'd0);
        run(45);
        chk("clear_relock", {31'd0, locked}, 32'd1);

        // Randomized dividers with occasional enable drops and clears.
        for (int s = 0; s < 25; s++) begin
            div = int'($urandom_range(2, 40));
            for (int c = 0; c < int'($urandom_range(50, 400)); c++)
                step($urandom_range(0, 299) != 0, $urandom_range(0, 199) == 0, 1'b0);
        end

        // Reset while confirming a new period.
        div = 20;
        run(100);
        hit_wrap = 1'b0;
        for (int i = 0; i < 30 && !hit_wrap; i++) step(1'b1, 1'b0, 1'b0);
        div = 13;
        run(15);
        #2 n_rst = 1'b0;
        #1;
        chk("midreset_locked", {31'd0, locked}, 32'd0);
        chk("midreset_period", {16'd0, period}, 32'd0);
        chk("midreset_valid", {31'd0, period_valid}, 32'd0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;
        run(100);
        chk("postreset_period", {16'd0, period}, 32'd13);

        // Minimum period 2, then a frozen count: single timeout.
        div = 2;
        run(20);
        chk("lock2_locked", {31'd0, locked}, 32'd1);
        chk("lock2_period", {16'd0, period}, 32'd2);
        timeouts_seen = 0;
        frozen = 1'b1;
        run(65540);
        chk("freeze_timeouts", timeouts_seen, 32'd1);
        chk("freeze_locked", {31'd0, locked}, 32'd0);
        chk("freeze_period", {16'd0, period}, 32'd0);

        run(5);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
